// File: rtl/frame_accumulator.sv
// Per-frame element-wise vector accumulator.
// Emits registered lane sums, vector count and sticky overflow at eof.
module frame_accumulator #(
    parameter int N         = 8,
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [N-1:0][WIDTH-1:0]       vector_in,
    output logic                          valid_out,
    output logic [N-1:0][ACC_WIDTH-1:0]   vector_out,
    output logic [CNT_WIDTH-1:0]          count_out,
    output logic                          overflow_out
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int MSB = ACC_WIDTH - 1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [N-1:0][ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic                          r_ovf;
    logic                          r_valid_out;
    logic [N-1:0][ACC_WIDTH-1:0]   r_vec_out;
    logic [CNT_WIDTH-1:0]          r_cnt_out;
    logic                          r_ovf_out;

    logic                          w_accum;
    logic [N-1:0][ACC_WIDTH-1:0]   w_base;
    logic [N-1:0][ACC_WIDTH-1:0]   w_ext;
    logic [N-1:0][ACC_WIDTH-1:0]   w_sum;
    logic [N-1:0]                  w_lane_ovf;
    logic [CNT_WIDTH-1:0]          w_cnt_base;
    logic [CNT_WIDTH-1:0]          w_cnt_sum;
    logic                          w_cnt_sat;
    logic                          w_ovf_sum;

    assign w_accum = (r_state == ACCUM);

    // In IDLE the accumulator is treated as zero so a new frame starts clean
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_base[i] = w_accum ? r_acc[i] : '0;
        assign w_ext[i]  = ACC_WIDTH'($signed(vector_in[i]));
        assign w_sum[i]  = w_base[i] + w_ext[i];
        assign w_lane_ovf[i] = (w_base[i][MSB] == w_ext[i][MSB]) &&
                               (w_sum[i][MSB] != w_base[i][MSB]);
    end

    assign w_cnt_base = w_accum ? r_cnt : '0;
    assign w_cnt_sat  = (w_cnt_base == CNT_MAX);
    assign w_cnt_sum  = w_cnt_sat ? CNT_MAX : w_cnt_base + 1'b1;
    assign w_ovf_sum  = (w_accum & r_ovf) | (|w_lane_ovf) | w_cnt_sat;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (valid_in && !eof_in) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (valid_in && eof_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_valid_out <= 1'b0;
            r_vec_out   <= '0;
            r_cnt_out   <= '0;
            r_ovf_out   <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (valid_in) begin
                if (eof_in) begin
                    r_valid_out <= 1'b1;
                    r_vec_out   <= w_sum;
                    r_cnt_out   <= w_cnt_sum;
                    r_ovf_out   <= w_ovf_sum;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_sum;
                    r_ovf <= w_ovf_sum;
                end
            end
        end
    end

    assign valid_out    = r_valid_out;
    assign vector_out   = r_vec_out;
    assign count_out    = r_cnt_out;
    assign overflow_out = r_ovf_out;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed self-checking bench for frame_accumulator.
// Instance A uses default widths, instance B is 8-bit with a 2-bit counter.
module tb_frame_accumulator;

    localparam int N = 8;

    logic clk;
    logic rst_n;

    logic                   a_valid, a_eof;
    logic [N-1:0][31:0]     a_vec;
    logic                   a_vout;
    logic [N-1:0][39:0]     a_vecout;
    logic [15:0]            a_cnt;
    logic                   a_ovf;

    logic                   b_rst_n;
    logic                   b_valid, b_eof;
    logic [N-1:0][7:0]      b_vec;
    logic                   b_vout;
    logic [N-1:0][7:0]      b_vecout;
    logic [1:0]             b_cnt;
    logic                   b_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    frame_accumulator #(
        .N(N), .WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(16)
    ) u_a (
        .clk_in(clk), .rst_n_in(rst_n),
        .valid_in(a_valid), .eof_in(a_eof), .vector_in(a_vec),
        .valid_out(a_vout), .vector_out(a_vecout),
        .count_out(a_cnt), .overflow_out(a_ovf)
    );

    frame_accumulator #(
        .N(N), .WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(2)
    ) u_b (
        .clk_in(clk), .rst_n_in(b_rst_n),
        .valid_in(b_valid), .eof_in(b_eof), .vector_in(b_vec),
        .valid_out(b_vout), .vector_out(b_vecout),
        .count_out(b_cnt), .overflow_out(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input longint v, input logic eof);
        a_valid = 1'b1;
        a_eof   = eof;
        for (int i = 0; i < N; i++) a_vec[i] = 32'(v);
        tick(1);
        a_valid = 1'b0;
        a_eof   = 1'b0;
    endtask

    task automatic send_b(input longint v, input logic eof);
        b_valid = 1'b1;
        b_eof   = eof;
        for (int i = 0; i < N; i++) b_vec[i] = 8'(v);
        tick(1);
        b_valid = 1'b0;
        b_eof   = 1'b0;
    endtask

    task automatic res_a(input string tag, input logic vld,
                         input longint lane, input int cnt,
                         input logic ovf);
        logic [39:0] e;
        e = 40'(lane);
        check({tag, ".valid"}, 64'(a_vout), 64'(vld));
        for (int i = 0; i < N; i++)
            check({tag, ".lane"}, 64'(a_vecout[i]), 64'(e));
        check({tag, ".count"}, 64'(a_cnt), 64'(cnt));
        check({tag, ".ovf"}, 64'(a_ovf), 64'(ovf));
    endtask

    task automatic res_b(input string tag, input logic vld,
                         input longint lane, input int cnt,
                         input logic ovf);
        logic [7:0] e;
        e = 8'(lane);
        check({tag, ".valid"}, 64'(b_vout), 64'(vld));
        for (int i = 0; i < N; i++)
            check({tag, ".lane"}, 64'(b_vecout[i]), 64'(e));
        check({tag, ".count"}, 64'(b_cnt), 64'(cnt));
        check({tag, ".ovf"}, 64'(b_ovf), 64'(ovf));
    endtask

    initial begin
        rst_n   = 1'b0;
        b_rst_n = 1'b0;
        a_valid = 1'b1;
        a_eof   = 1'b1;
        b_valid = 1'b1;
        b_eof   = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_vec[i] = 32'h1234;
            b_vec[i] = 8'h7f;
        end
        tick(3);
        res_a("rst_a", 1'b0, 0, 0, 1'b0);
        res_b("rst_b", 1'b0, 0, 0, 1'b0);
        a_valid = 1'b0;
        a_eof   = 1'b0;
        b_valid = 1'b0;
        b_eof   = 1'b0;
        rst_n   = 1'b1;
        b_rst_n = 1'b1;
        tick(1);

        send_a(1, 1'b0);
        send_a(2, 1'b0);
        check("basic.pre", 64'(a_vout), 64'(0));
        send_a(3, 1'b1);
        res_a("basic", 1'b1, 6, 3, 1'b0);
        tick(1);
        res_a("basic.hold", 1'b0, 6, 3, 1'b0);

        send_a(-5, 1'b0);
        send_a(2, 1'b1);
        res_a("signed", 1'b1, -3, 2, 1'b0);
        check("signed.raw", 64'(a_vecout[0]), 64'h00FF_FFFF_FFFD);

        a_eof = 1'b1;
        tick(1);
        a_eof = 1'b0;
        check("gap.ign", 64'(a_vout), 64'(0));
        send_a(4, 1'b0);
        tick(2);
        check("gap.idle", 64'(a_vout), 64'(0));
        send_a(4, 1'b1);
        res_a("gap", 1'b1, 8, 2, 1'b0);
        tick(1);
        check("gap.pulse", 64'(a_vout), 64'(0));

        send_a(10, 1'b1);
        res_a("b2b0", 1'b1, 10, 1, 1'b0);
        send_a(20, 1'b1);
        res_a("b2b1", 1'b1, 20, 1, 1'b0);
        send_a(30, 1'b1);
        res_a("b2b2", 1'b1, 30, 1, 1'b0);
        send_a(40, 1'b1);
        res_a("b2b3", 1'b1, 40, 1, 1'b0);
        tick(1);
        check("b2b.end", 64'(a_vout), 64'(0));

        send_b(100, 1'b0);
        send_b(100, 1'b1);
        res_b("ovf", 1'b1, -56, 2, 1'b1);
        send_b(1, 1'b1);
        res_b("ovf.clr", 1'b1, 1, 1, 1'b0);

        send_b(1, 1'b0);
        send_b(1, 1'b0);
        send_b(1, 1'b0);
        send_b(1, 1'b1);
        res_b("sat", 1'b1, 4, 3, 1'b1);
        send_b(2, 1'b1);
        res_b("sat.clr", 1'b1, 2, 1, 1'b0);

        send_b(1, 1'b0);
        send_b(1, 1'b0);
        b_rst_n = 1'b0;
        b_valid = 1'b1;
        b_eof   = 1'b1;
        for (int i = 0; i < N; i++) b_vec[i] = 8'd9;
        tick(1);
        b_valid = 1'b0;
        b_eof   = 1'b0;
        b_rst_n = 1'b1;
        res_b("midrst", 1'b0, 0, 0, 1'b0);
        send_b(5, 1'b1);
        res_b("midrst.f", 1'b1, 5, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
